// File: rtl/correlation_stream_gen.sv
// correlation_stream_gen
//   Serializes pairs of parallel words MSB-first onto two aligned bit lanes
//   for the serial cross-correlator, and tracks the running ones-balance
//   (x ones minus y ones) of the emitted stream with the correlator's
//   one-cycle lag.
//
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   valid_i        : word pair offered (accepted when ready_o is high)
//   x_word_i       : x-lane word
//   y_word_i       : y-lane word
//   ready_o        : block is IDLE and can accept a word pair
//   sig_x_o/_y_o   : serial lane bits
//   sig_vld_o      : lanes carry a live bit
//   done_o         : pulse with the last bit of a word
//   balance_o      : signed running (x ones - y ones) for the current word
//   balance_nz_o   : balance_o is non-zero
module correlation_stream_gen #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned IDLE_GAP = 0,
    parameter int unsigned BAL_W    = $clog2(WIDTH + 1) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] x_word_i,
    input  logic [WIDTH-1:0] y_word_i,
    output logic             ready_o,
    output logic             sig_x_o,
    output logic             sig_y_o,
    output logic             sig_vld_o,
    output logic             done_o,
    output logic [BAL_W-1:0] balance_o,
    output logic             balance_nz_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_sh_q;
    logic [WIDTH-1:0] y_sh_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic             sig_x_q;
    logic             sig_y_q;
    logic             sig_vld_q;
    logic             done_q;
    logic [BAL_W-1:0] balance_q;
    logic [BAL_W-1:0] balance_d;

    // Balance follows the bit currently on the lanes, so it lags the
    // emitted stream by one cycle exactly like the correlator's count.
    always_comb begin
        balance_d = balance_q + BAL_W'(sig_x_q) - BAL_W'(sig_y_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_sh_q    <= '0;
            y_sh_q    <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            sig_x_q   <= 1'b0;
            sig_y_q   <= 1'b0;
            sig_vld_q <= 1'b0;
            done_q    <= 1'b0;
            balance_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        // The MSB goes straight to the output register;
                        // the shift registers hold the remaining bits.
                        state_q   <= S_SHIFT;
                        sig_x_q   <= x_word_i[WIDTH-1];
                        sig_y_q   <= y_word_i[WIDTH-1];
                        x_sh_q    <= {x_word_i[WIDTH-2:0], 1'b0};
                        y_sh_q    <= {y_word_i[WIDTH-2:0], 1'b0};
                        sig_vld_q <= 1'b1;
                        done_q    <= 1'b0;
                        cnt_q     <= '0;
                        balance_q <= '0;
                    end
                end
                S_SHIFT: begin
                    balance_q <= balance_d;
                    if (cnt_q == LAST_CNT) begin
                        sig_x_q   <= 1'b0;
                        sig_y_q   <= 1'b0;
                        sig_vld_q <= 1'b0;
                        done_q    <= 1'b0;
                        gap_q     <= '0;
                        state_q   <= (IDLE_GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        sig_x_q <= x_sh_q[WIDTH-1];
                        sig_y_q <= y_sh_q[WIDTH-1];
                        x_sh_q  <= {x_sh_q[WIDTH-2:0], 1'b0};
                        y_sh_q  <= {y_sh_q[WIDTH-2:0], 1'b0};
                        cnt_q   <= cnt_q + 1'b1;
                        done_q  <= (cnt_q == PRE_LAST);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o      = (state_q == S_IDLE);
    assign sig_x_o      = sig_x_q;
    assign sig_y_o      = sig_y_q;
    assign sig_vld_o    = sig_vld_q;
    assign done_o       = done_q;
    assign balance_o    = balance_q;
    assign balance_nz_o = |balance_q;

endmodule

// File: doc/correlation_stream_gen.md
# correlation_stream_gen

Transmit-side companion to the serial cross-correlator. It accepts pairs of parallel words over a valid/ready handshake and serializes them MSB-first onto two aligned bit lanes, `sig_x_o` and `sig_y_o`, which feed the correlator's `sig_x_i` and `sig_y_i` inputs. While it sends, it keeps the running ones-balance of the emitted stream (x ones minus y ones) in the same form the correlator uses. Benches and self-test logic use that balance as the expected correlator state.

## Interface
- `WIDTH`, default 16: bits per word per lane. Must be at least 2.
- `IDLE_GAP`, default 0: forced idle cycles after each word before `ready_o` rises again.
- `BAL_W`, derived as $clog2(WIDTH+1)+1 (6 for WIDTH=16): width of the signed balance.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high. It has priority over every other input.
- `valid_i`, in, 1: a word pair is offered.
- `x_word_i`, in, WIDTH: x-lane word, sampled when the handshake completes.
- `y_word_i`, in, WIDTH: y-lane word, sampled when the handshake completes.
- `ready_o`, out, 1: block can accept a word pair (high only in IDLE).
- `sig_x_o`, out, 1: serial x bit.
- `sig_y_o`, out, 1: serial y bit.
- `sig_vld_o`, out, 1: `sig_x_o` and `sig_y_o` carry a live bit this cycle.
- `done_o`, out, 1: one-cycle pulse that coincides with the last bit of a word.
- `balance_o`, out, BAL_W: signed two's-complement running (x ones − y ones) for the current word.
- `balance_nz_o`, out, 1: `|balance_o`.

## Operation
- The FSM has three states: IDLE, SHIFT, GAP.
  - IDLE goes to SHIFT on `valid_i & ready_o`.
  - SHIFT goes to GAP after the bit with index WIDTH−1 if IDLE_GAP>0; otherwise it goes to IDLE.
  - GAP goes to IDLE after IDLE_GAP cycles.
- On accept, both words are loaded into shift registers, the bit counter is cleared, and `balance_o` is cleared to 0.
- In SHIFT:
  - Each cycle presents `x_sh[WIDTH-1]` and `y_sh[WIDTH-1]` as registered outputs, then shifts left by one.
  - `sig_vld_o` is 1.
  - The bit counter increments. It is $clog2(WIDTH) bits wide and never wraps inside a word.
- Balance update, one cycle after each emitted bit: `balance_o <= balance_o + x_bit − y_bit`.
  - Both bits are zero-extended to BAL_W before the arithmetic.
  - Equal bits leave the balance unchanged.
  - Range is ±WIDTH. No saturation is needed because BAL_W covers it.
- `balance_o` holds its final value through GAP and IDLE until the next accept.
- Outside SHIFT: `sig_x_o`, `sig_y_o`, `sig_vld_o` and `done_o` are 0.
- `ready_o` is `(state == IDLE)`.
- In any state other than IDLE, `valid_i` and the word inputs are ignored. A word is never accepted in the same cycle that `reset` is high.
- Reset asserted mid-SHIFT or mid-GAP:
  - Aborts the word; the remaining bits are never sent.
  - Next cycle the state is IDLE and every output is at its reset value.
- Reset values:
  - `ready_o` = 1 (state IDLE).
  - `sig_x_o`, `sig_y_o`, `sig_vld_o`, `done_o` = 0.
  - `balance_o` = 0, `balance_nz_o` = 0.

## Timing
- Handshake at cycle T (`valid_i & ready_o`):
  - Bit k (MSB first, k = 0..WIDTH−1) appears on the lanes in cycle T+1+k with `sig_vld_o` = 1.
  - `done_o` = 1 in cycle T+WIDTH.
- `balance_o` in cycle T+1+k reflects bits 0..k−1.
  - It is 0 at T+1.
  - The final value appears at T+WIDTH+1.
  - This one-cycle lag matches the correlator's registered count.
- `ready_o` is low from T+1 through T+WIDTH+IDLE_GAP and high again at T+WIDTH+IDLE_GAP+1.
- Minimum word period is WIDTH+1+IDLE_GAP cycles. With IDLE_GAP=0 and `valid_i` held high, there is exactly one non-valid lane cycle between consecutive words.

## Test plan
- Single word, x=16'hFFFF, y=16'h0000, accept at T:
  - `sig_vld_o` is high for T+1..T+16.
  - `done_o` pulses at T+16.
  - `balance_o` = 16 (6'h10) at T+17; `balance_nz_o` = 1.
- Single word, x=16'h0000, y=16'hFFFF:
  - `balance_o` = −16 (6'h30) at T+17.
  - Each intermediate value decrements by 1 per cycle.
- Single word, x=y=16'hA5A5:
  - Lanes are identical each cycle.
  - `balance_o` stays 0 throughout; `balance_nz_o` is never 1.
- Back-to-back with `valid_i` held high, words (16'h8000, 16'h0001) then (16'h0001, 16'h8000):
  - Second accept occurs at T+17; its first bit appears at T+18.
  - First word: `balance_o` rises to +1 at T+2, drops to 0 at T+17.
  - Second word: `balance_o` clears at T+18, goes to −1 at T+19, returns to 0 at T+34.
- Reset asserted in the cycle that carries bit 5 of x=16'hFFFF, y=0:
  - The next cycle shows `ready_o` = 1, all lane and strobe outputs 0, `balance_o` = 0.
  - A fresh word accepted afterwards serializes from its MSB.
- IDLE_GAP=3, WIDTH=8:
  - After accept at T, `done_o` pulses at T+8.
  - `ready_o` is low through T+11 and high at T+12.
  - `valid_i` asserted during T+9..T+11 is not accepted.
